uart_hex_line_tx: RTL and testbench

Synthesizable UART transmitter that prints one data word as a line of uppercase ASCII hex digits, MSB nibble first, terminated by 0x0A ('\n').
Sits in the user project between a register/debug source and the chip serial pin (ser_tx).
The 9600-baud line monitor in the DV bench consumes its output and decodes each line back to a value.
Uses a valid/ready handshake on the input side and a 8N1 serializer on the output side.

---
 rtl/uart_hex_line_tx_if.sv | 13 +
 rtl/uart_hex_line_tx.sv | 162 ++++++++++++++++
 tb/tb_uart_hex_line_tx.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_hex_line_tx_if.sv
// Input-side handshake for uart_hex_line_tx: one word per accepted valid/ready.
interface uart_hex_line_tx_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_i;
  logic              valid_i;
  logic              ready_o;

  // Word source: offers data and valid, observes ready.
  modport master (output data_i, output valid_i, input ready_o);
  // Printer: consumes data and valid, reports ready.
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_hex_line_tx.sv
// Prints one accepted word as a line of uppercase hex digits (MSB nibble
// first) followed by '\n', serialized as 8N1 UART on ser_tx.
module uart_hex_line_tx #(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 1042,
  parameter int SUPPRESS_LZ  = 0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  uart_hex_line_tx_if.slave   s_if,
  output logic                busy_o,
  output logic                done_o,
  output logic                ser_tx
);

  localparam int NIB   = (DATA_W + 3) / 4;
  localparam int SH_W  = NIB * 4;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int DIG_W = $clog2(NIB + 1);
  localparam logic [7:0] NL = 8'h0A;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           state_q;
  logic             ser_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;

  logic [SH_W-1:0]  shift_q;   // remaining digits, current one in the top nibble
  logic [DIG_W-1:0] dig_q;     // digits still to send after the current one
  logic [7:0]       char_q;    // character currently on the line

  logic [SH_W-1:0]  pad_d;
  logic [DIG_W-1:0] lz_d;
  logic             zero_run;
  logic [SH_W-1:0]  load_shift_d;
  logic [DIG_W-1:0] load_dig_d;
  logic [SH_W-1:0]  next_shift_d;
  logic             bit_end;
  logic             accept;
  logic             char_end;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  assign bit_end  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
  assign accept   = (state_q == S_IDLE) && ready_q && s_if.valid_i;
  assign char_end = (state_q == S_STOP) && bit_end;

  // Count leading zero nibbles to skip; digit 0 is never skipped.
  always_comb begin
    pad_d    = SH_W'(s_if.data_i);
    lz_d     = '0;
    zero_run = 1'b1;
    if (SUPPRESS_LZ != 0) begin
      for (int i = NIB - 1; i >= 1; i--) begin
        if (zero_run && (pad_d[i*4 +: 4] == 4'h0)) lz_d = lz_d + DIG_W'(1);
        else                                       zero_run = 1'b0;
      end
    end
    load_shift_d = pad_d << {lz_d, 2'b00};
    load_dig_d   = DIG_W'(NIB - 1) - lz_d;
    next_shift_d = shift_q << 4;
  end

  // Character datapath: load on acceptance, pick the next char as a stop bit ends.
  // NOTE: datapath registers carry no reset; they are always loaded on acceptance before use.
  always_ff @(posedge wb_clk_i) begin
    if (accept) begin
      shift_q <= load_shift_d;
      dig_q   <= load_dig_d;
      char_q  <= hex_char(load_shift_d[SH_W-1 -: 4]);
    end else if (char_end && (char_q != NL)) begin
      if (dig_q == '0) begin
        char_q <= NL;
      end else begin
        shift_q <= next_shift_d;
        dig_q   <= dig_q - DIG_W'(1);
        char_q  <= hex_char(next_shift_d[SH_W-1 -: 4]);
      end
    end
  end

  // Line FSM with bit timing; all outputs registered.
  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      ser_q   <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      // NOTE: done_q defaults low each cycle so it can only ever be a single-cycle pulse.
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (accept) begin
            ser_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            ser_q   <= char_q[0];
            state_q <= S_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              ser_q   <= 1'b1;
              state_q <= S_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
              ser_q <= char_q[bit_q + 3'd1];
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (char_q == NL) begin
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ser_q   <= 1'b0;
              state_q <= S_START;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign s_if.ready_o = ready_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ser_tx       = ser_q;

endmodule

// File: tb/tb_uart_hex_line_tx.sv
// Directed bench for uart_hex_line_tx: three instances (plain 32-bit,
// leading-zero suppression, 12-bit word), decoded through a UART receiver task.
module tb_uart_hex_line_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int          sel = 0;
  logic [31:0] data_v = '0;
  logic        valid_v = 1'b0;

  uart_hex_line_tx_if #(.DATA_W(32)) if0 ();
  uart_hex_line_tx_if #(.DATA_W(32)) if1 ();
  uart_hex_line_tx_if #(.DATA_W(12)) if2 ();

  logic busy0, done0, ser0, busy1, done1, ser1, busy2, done2, ser2;

  assign if0.data_i  = data_v;
  assign if1.data_i  = data_v;
  assign if2.data_i  = data_v[11:0];
  assign if0.valid_i = valid_v && (sel == 0);
  assign if1.valid_i = valid_v && (sel == 1);
  assign if2.valid_i = valid_v && (sel == 2);

  uart_hex_line_tx #(.DATA_W(32), .CLKS_PER_BIT(CPB), .SUPPRESS_LZ(0)) dut0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .s_if(if0), .busy_o(busy0), .done_o(done0), .ser_tx(ser0));
  uart_hex_line_tx #(.DATA_W(32), .CLKS_PER_BIT(CPB), .SUPPRESS_LZ(1)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .s_if(if1), .busy_o(busy1), .done_o(done1), .ser_tx(ser1));
  uart_hex_line_tx #(.DATA_W(12), .CLKS_PER_BIT(CPB), .SUPPRESS_LZ(0)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .s_if(if2), .busy_o(busy2), .done_o(done2), .ser_tx(ser2));

  // Observed instance, chosen by sel.
  logic ser_m, ready_m, busy_m, done_m;
  always_comb begin
    ser_m = ser0; ready_m = if0.ready_o; busy_m = busy0; done_m = done0;
    case (sel)
      1: begin ser_m = ser1; ready_m = if1.ready_o; busy_m = busy1; done_m = done1; end
      2: begin ser_m = ser2; ready_m = if2.ready_o; busy_m = busy2; done_m = done2; end
      default: ;
    endcase
  end

  // Free-running activity counters; the stimulus snapshots and subtracts.
  int busy_cnt = 0, done_cnt = 0, rdy_low_cnt = 0;
  always @(negedge clk) begin
    if (busy_m)   busy_cnt    <= busy_cnt + 1;
    if (done_m)   done_cnt    <= done_cnt + 1;
    if (!ready_m) rdy_low_cnt <= rdy_low_cnt + 1;
  end
  int b_busy, b_done, b_rdy;

  int n_checks = 0, n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_str(input string tag, input string obs, input string exp);
    n_checks++;
    assert (obs == exp) else begin
      n_errors++;
      $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
    end
  endtask

  task automatic snap();
    b_busy = busy_cnt; b_done = done_cnt; b_rdy = rdy_low_cnt;
  endtask

  // Receive one 8N1 char; already_low means the current cycle is start-bit cycle 0.
  task automatic rx_char(input bit already_low, output logic [7:0] c, output int waited);
    bit found;
    found  = already_low;
    waited = 0;
    c      = 8'h00;
    while (!found && waited < 400) begin
      @(negedge clk);
      waited++;
      if (ser_m == 1'b0) found = 1'b1;
    end
    check("start_seen", found, 1);
    if (found) begin
      repeat (CPB / 2) @(negedge clk);
      check("start_mid", ser_m, 0);
      for (int b = 0; b < 8; b++) begin
        repeat (CPB) @(negedge clk);
        c[b] = ser_m;
      end
      repeat (CPB) @(negedge clk);
      check("stop_bit", ser_m, 1);
    end
  endtask

  // Receive a line up to '\n'; returns the digits and the wait before the first start bit.
  task automatic rx_line(input bit already_low, output string s, output int first_wait);
    logic [7:0] c;
    int         w;
    bit         low, fin;
    s = ""; low = already_low; fin = 1'b0; first_wait = 0;
    for (int n = 0; n < 12 && !fin; n++) begin
      rx_char(low, c, w);
      if (n == 0) first_wait = w;
      else        check("char_gap", w, 2);
      low = 1'b0;
      if (c == 8'h0A) fin = 1'b1;
      else            s = $sformatf("%s%c", s, c);
    end
    check("line_newline", fin, 1);
  endtask

  // Pulse valid for one cycle; leaves the bench at start-bit cycle 0.
  task automatic send(input int which, input logic [31:0] d);
    sel = which;
    @(negedge clk);
    snap();
    data_v = d; valid_v = 1'b1;
    @(negedge clk);
    valid_v = 1'b0;
    check("start_latency_ser", ser_m, 0);
    check("accept_ready", ready_m, 0);
    check("accept_busy", busy_m, 1);
  endtask

  // From mid stop bit of '\n': check completion cycle and line-level counts.
  task automatic finish_line(input int exp_busy);
    repeat (2) @(negedge clk);
    check("done_pulse", done_m, 1);
    check("done_ready", ready_m, 1);
    check("done_busy", busy_m, 0);
    check("done_ser_idle", ser_m, 1);
    @(negedge clk);
    check("done_one_cycle", done_m, 0);
    check("busy_cycles", busy_cnt - b_busy, exp_busy);
    check("done_count", done_cnt - b_done, 1);
  endtask

  string s;
  int    w;

  initial begin
    // Reset values on every instance.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      @(negedge clk);
      check("rst_ser", ser_m, 1);
      check("rst_ready", ready_m, 1);
      check("rst_busy", busy_m, 0);
      check("rst_done", done_m, 0);
    end

    // Basic line: 9 chars x 10 bits x 4 clocks = 360 busy cycles.
    send(0, 32'h000000FF);
    rx_line(1'b1, s, w);
    check_str("line_ff", s, "000000FF");
    finish_line(360);

    // All letter digits.
    send(0, 32'hDEADBEEF);
    rx_line(1'b1, s, w);
    check_str("line_deadbeef", s, "DEADBEEF");
    finish_line(360);

    // Leading-zero suppression: "0\n" (2 chars) and "A10\n" (4 chars).
    send(1, 32'h0);
    rx_line(1'b1, s, w);
    check_str("slz_zero", s, "0");
    finish_line(80);
    send(1, 32'h00000A10);
    rx_line(1'b1, s, w);
    check_str("slz_a10", s, "A10");
    finish_line(160);

    // Valid and data change mid-line are ignored.
    send(0, 32'h0BADF00D);
    fork
      rx_line(1'b1, s, w);
      begin
        repeat (100) @(negedge clk);
        data_v = 32'h12345678; valid_v = 1'b1;
        repeat (20) @(negedge clk);
        valid_v = 1'b0;
      end
    join
    check_str("midline_ignored", s, "0BADF00D");
    finish_line(360);
    check("ready_low_cycles", rdy_low_cnt - b_rdy, 360);
    repeat (50) @(negedge clk);
    check("no_queued_busy", busy_m, 0);
    check("no_queued_ser", ser_m, 1);

    // Reset during bit 1 (a 0 bit) of digit 3 ('5' = 0x35), cycle 169 of the line.
    send(0, 32'h12345678);
    repeat (169) @(negedge clk);
    check("pre_rst_low", ser_m, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_ser", ser_m, 1);
    check("midrst_ready", ready_m, 1);
    check("midrst_busy", busy_m, 0);
    check("midrst_done", done_m, 0);
    repeat (20) @(negedge clk);
    check("midrst_no_done", done_cnt - b_done, 0);
    check("midrst_quiet", ser_m, 1);
    send(0, 32'h1);
    rx_line(1'b1, s, w);
    check_str("after_rst", s, "00000001");
    finish_line(360);

    // Held valid: back-to-back lines, data switched on the done cycle.
    sel = 0;
    @(negedge clk);
    data_v = 32'hA; valid_v = 1'b1;
    rx_line(1'b0, s, w);
    check("b2b_first_latency", w, 1);
    check_str("b2b_line_a", s, "0000000A");
    repeat (2) @(negedge clk);
    check("b2b_done", done_m, 1);
    check("b2b_ready", ready_m, 1);
    data_v = 32'hB;
    @(negedge clk);
    snap();
    check("b2b_restart_ser", ser_m, 0);
    check("b2b_restart_busy", busy_m, 1);
    valid_v = 1'b0;
    rx_line(1'b1, s, w);
    check_str("b2b_line_b", s, "0000000B");
    finish_line(360);

    // 12-bit word: 3 digits per line.
    send(2, 32'h00000ABC);
    rx_line(1'b1, s, w);
    check_str("dw12_line", s, "ABC");
    finish_line(160);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
